// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename (busy/tag) state.
// Commits from the ROB, destination locks from decode, two operand lookups.
module reg_file_rename #(
    parameter int REG_NUM     = 32,
    parameter int REG_WIDTH   = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int ENTRY_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   commit_enable,
    input  logic [REG_WIDTH-1:0]   commit_name,
    input  logic [DATA_WIDTH-1:0]  commit_data,
    input  logic [ENTRY_WIDTH-1:0] commit_entry,
    input  logic                   lock_enable,
    input  logic [REG_WIDTH-1:0]   lock_name,
    input  logic [ENTRY_WIDTH-1:0] lock_entry,
    input  logic                   flush,
    input  logic                   read1,
    input  logic [REG_WIDTH-1:0]   read_name1,
    output logic [DATA_WIDTH-1:0]  read_value1,
    output logic                   read_busy1,
    output logic [ENTRY_WIDTH-1:0] read_tag1,
    input  logic                   read2,
    input  logic [REG_WIDTH-1:0]   read_name2,
    output logic [DATA_WIDTH-1:0]  read_value2,
    output logic                   read_busy2,
    output logic [ENTRY_WIDTH-1:0] read_tag2
);

    logic [DATA_WIDTH-1:0]  r_data [REG_NUM];
    logic [ENTRY_WIDTH-1:0] r_tag  [REG_NUM];
    logic [REG_NUM-1:0]     r_busy;

    logic [REG_NUM-1:0]     w_commit_sel;
    logic [REG_NUM-1:0]     w_lock_sel;
    logic [REG_NUM-1:0]     w_release;

    // Register 0 is never selected, so it keeps its reset value forever.
    always_comb begin
        w_commit_sel = '0;
        w_lock_sel   = '0;
        if (commit_enable && commit_name != '0) begin
            w_commit_sel[commit_name] = 1'b1;
        end
        if (lock_enable && lock_name != '0 && !flush) begin
            w_lock_sel[lock_name] = 1'b1;
        end
    end

    // Only the newest writer (matching tag) may release the rename.
    for (genvar g = 0; g < REG_NUM; g++) begin : g_release
        assign w_release[g] = w_commit_sel[g] && r_busy[g] &&
                              (r_tag[g] == commit_entry);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (w_commit_sel[i]) begin
                    r_data[i] <= commit_data;
                end
                if (flush) begin
                    r_busy[i] <= 1'b0;
                end else if (w_lock_sel[i]) begin
                    r_busy[i] <= 1'b1;
                    r_tag[i]  <= lock_entry;
                end else if (w_release[i]) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        read_value1 = '0;
        read_busy1  = 1'b0;
        read_tag1   = '0;
        if (!rst && read1 && read_name1 != '0) begin
            if (w_release[read_name1]) begin
                read_value1 = commit_data;
            end else if (r_busy[read_name1]) begin
                read_busy1 = 1'b1;
                read_tag1  = r_tag[read_name1];
            end else begin
                read_value1 = r_data[read_name1];
            end
        end
    end

    always_comb begin
        read_value2 = '0;
        read_busy2  = 1'b0;
        read_tag2   = '0;
        if (!rst && read2 && read_name2 != '0) begin
            if (w_release[read_name2]) begin
                read_value2 = commit_data;
            end else if (r_busy[read_name2]) begin
                read_busy2 = 1'b1;
                read_tag2  = r_tag[read_name2];
            end else begin
                read_value2 = r_data[read_name2];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed bench for reg_file_rename: expected lookups are queued when a
// read is requested and popped/compared when the outputs are sampled.
module tb_reg_file_rename;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_enable;
    logic [4:0]  commit_name;
    logic [31:0] commit_data;
    logic [2:0]  commit_entry;
    logic        lock_enable;
    logic [4:0]  lock_name;
    logic [2:0]  lock_entry;
    logic        flush;
    logic        read1, read2;
    logic [4:0]  read_name1, read_name2;
    logic [31:0] read_value1, read_value2;
    logic        read_busy1, read_busy2;
    logic [2:0]  read_tag1, read_tag2;

    typedef struct {
        string       nm;
        int          port;
        logic [31:0] v;
        logic        b;
        logic [2:0]  t;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    reg_file_rename dut (
        .clk          (clk),
        .rst          (rst),
        .commit_enable(commit_enable),
        .commit_name  (commit_name),
        .commit_data  (commit_data),
        .commit_entry (commit_entry),
        .lock_enable  (lock_enable),
        .lock_name    (lock_name),
        .lock_entry   (lock_entry),
        .flush        (flush),
        .read1        (read1),
        .read_name1   (read_name1),
        .read_value1  (read_value1),
        .read_busy1   (read_busy1),
        .read_tag1    (read_tag1),
        .read2        (read2),
        .read_name2   (read_name2),
        .read_value2  (read_value2),
        .read_busy2   (read_busy2),
        .read_tag2    (read_tag2)
    );

    task automatic idle();
        commit_enable = 1'b0;
        commit_name   = '0;
        commit_data   = '0;
        commit_entry  = '0;
        lock_enable   = 1'b0;
        lock_name     = '0;
        lock_entry    = '0;
        flush         = 1'b0;
        read1         = 1'b0;
        read_name1    = '0;
        read2         = 1'b0;
        read_name2    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic commit(input logic [4:0] n, input logic [31:0] d,
                          input logic [2:0] e);
        commit_enable = 1'b1;
        commit_name   = n;
        commit_data   = d;
        commit_entry  = e;
    endtask

    task automatic lock(input logic [4:0] n, input logic [2:0] e);
        lock_enable = 1'b1;
        lock_name   = n;
        lock_entry  = e;
    endtask

    task automatic req(input string nm, input int port, input logic en,
                       input logic [4:0] n, input logic [31:0] v,
                       input logic b, input logic [2:0] t);
        exp_t e;
        if (port == 1) begin
            read1      = en;
            read_name1 = n;
        end else begin
            read2      = en;
            read_name2 = n;
        end
        e.nm = nm; e.port = port; e.v = v; e.b = b; e.t = t;
        q.push_back(e);
    endtask

    task automatic sample();
        exp_t        e;
        logic [35:0] obs;
        logic [35:0] exp;
        #1;
        while (q.size() > 0) begin
            e   = q.pop_front();
            exp = {e.v, e.b, e.t};
            obs = (e.port == 1) ? {read_value1, read_busy1, read_tag1}
                                : {read_value2, read_busy2, read_tag2};
            total++;
            assert (obs === exp) passed++;
            else $error("FAIL %s port%0d: value/busy/tag got %h/%b/%0d want %h/%b/%0d",
                        e.nm, e.port, obs[35:4], obs[3], obs[2:0],
                        e.v, e.b, e.t);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #2;
        req("rst_read", 1, 1'b1, 5'd5, 32'h0, 1'b0, 3'd0);
        sample();
        tick();
        tick();
        #2 rst = 1'b0;
        tick();

        // commit without lock
        req("r5_init", 1, 1'b1, 5'd5, 32'h0, 1'b0, 3'd0);
        sample();
        commit(5'd5, 32'hDEADBEEF, 3'd2);
        req("r5_unlocked_commit", 1, 1'b1, 5'd5, 32'h0, 1'b0, 3'd0);
        sample();
        tick();
        req("r5_after", 1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 3'd0);
        req("r5_disabled", 2, 1'b0, 5'd5, 32'h0, 1'b0, 3'd0);
        sample();

        // lock then matching commit with bypass
        lock(5'd3, 3'd4);
        tick();
        req("r3_locked", 1, 1'b1, 5'd3, 32'h0, 1'b1, 3'd4);
        sample();
        commit(5'd3, 32'h11, 3'd4);
        req("r3_bypass", 1, 1'b1, 5'd3, 32'h11, 1'b0, 3'd0);
        req("r5_port2", 2, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 3'd0);
        sample();
        tick();
        req("r3_released", 2, 1'b1, 5'd3, 32'h11, 1'b0, 3'd0);
        sample();

        // stale commit must not release a younger lock
        lock(5'd7, 3'd1);
        tick();
        lock(5'd7, 3'd6);
        tick();
        commit(5'd7, 32'h22, 3'd1);
        req("r7_stale_commit", 1, 1'b1, 5'd7, 32'h0, 1'b1, 3'd6);
        sample();
        tick();
        req("r7_still_busy", 1, 1'b1, 5'd7, 32'h0, 1'b1, 3'd6);
        sample();
        commit(5'd7, 32'h33, 3'd6);
        req("r7_bypass", 2, 1'b1, 5'd7, 32'h33, 1'b0, 3'd0);
        sample();
        tick();
        req("r7_final", 1, 1'b1, 5'd7, 32'h33, 1'b0, 3'd0);
        sample();

        // same-cycle commit and lock: lock wins busy/tag
        lock(5'd9, 3'd2);
        tick();
        commit(5'd9, 32'h44, 3'd2);
        lock(5'd9, 3'd5);
        req("r9_same_cycle", 1, 1'b1, 5'd9, 32'h44, 1'b0, 3'd0);
        sample();
        tick();
        req("r9_relocked", 1, 1'b1, 5'd9, 32'h0, 1'b1, 3'd5);
        sample();
        flush = 1'b1;
        tick();
        req("r9_data_kept", 2, 1'b1, 5'd9, 32'h44, 1'b0, 3'd0);
        sample();

        // flush clears busy and drops a same-cycle lock
        lock(5'd1, 3'd1);
        tick();
        lock(5'd2, 3'd2);
        tick();
        lock(5'd4, 3'd3);
        tick();
        req("r1_locked", 1, 1'b1, 5'd1, 32'h0, 1'b1, 3'd1);
        req("r2_locked", 2, 1'b1, 5'd2, 32'h0, 1'b1, 3'd2);
        sample();
        flush = 1'b1;
        lock(5'd8, 3'd7);
        req("r4_pre_flush", 1, 1'b1, 5'd4, 32'h0, 1'b1, 3'd3);
        sample();
        tick();
        req("r1_flushed", 1, 1'b1, 5'd1, 32'h0, 1'b0, 3'd0);
        req("r2_flushed", 2, 1'b1, 5'd2, 32'h0, 1'b0, 3'd0);
        sample();
        req("r4_flushed", 1, 1'b1, 5'd4, 32'h0, 1'b0, 3'd0);
        req("r8_not_locked", 2, 1'b1, 5'd8, 32'h0, 1'b0, 3'd0);
        sample();

        // asynchronous reset mid-cycle
        commit(5'd10, 32'h66, 3'd0);
        tick();
        req("r10_written", 1, 1'b1, 5'd10, 32'h66, 1'b0, 3'd0);
        req("r3_before_rst", 2, 1'b1, 5'd3, 32'h11, 1'b0, 3'd0);
        sample();
        #1 rst = 1'b1;
        req("r10_async_rst", 1, 1'b1, 5'd10, 32'h0, 1'b0, 3'd0);
        sample();
        tick();
        #2 rst = 1'b0;
        tick();
        req("r10_cleared", 1, 1'b1, 5'd10, 32'h0, 1'b0, 3'd0);
        req("r5_cleared", 2, 1'b1, 5'd5, 32'h0, 1'b0, 3'd0);
        sample();

        // register 0 is hardwired
        commit(5'd0, 32'h77, 3'd3);
        lock(5'd0, 3'd3);
        req("r0_same_cycle", 1, 1'b1, 5'd0, 32'h0, 1'b0, 3'd0);
        req("r0_same_cycle", 2, 1'b1, 5'd0, 32'h0, 1'b0, 3'd0);
        sample();
        tick();
        req("r0_after", 1, 1'b1, 5'd0, 32'h0, 1'b0, 3'd0);
        req("r0_after", 2, 1'b1, 5'd0, 32'h0, 1'b0, 3'd0);
        sample();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
